// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Control unit for a multicycle MIPS-style datapath. A two-process FSM
//   walks each instruction through fetch, decode and its execute/memory/
//   write-back phases. It drives the datapath mux selects, write enables
//   and the ALU operation code.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   opcode     in   [5:0] instruction bits 31:26 (used live only in DECODE)
//   funct      in   [5:0] instruction bits 5:0  (used live only in DECODE)
//   zero       in   ALU zero flag, gates pc_write in BRANCH
//   mem_ready  in   memory handshake, looked at in FETCH, MEMRD and MEMWR
//   pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_a   out [0:0]
//   alu_src_b, pc_src, reg_dst, mem_to_reg                          out [1:0]
//   alu_ctl    out  [3:0] team ALU operation code
//   illegal    out  high while parked in TRAP
//   state      out  [3:0] current state code
// ---------------------------------------------------------------------------
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [3:0] alu_ctl,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB   = 4'd7,
        S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JAL   = 4'd11,
        S_JR     = 4'd12, S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_JR   = 4'b1111;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_LW   = 4'b1000;
    localparam logic [3:0] ALU_SW   = 4'b1001;
    localparam logic [3:0] ALU_ADDI = 4'b0011;
    localparam logic [3:0] ALU_ANDI = 4'b0001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_JAL  = 4'b1011;

    state_t     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic [5:0] funct_q, funct_d;
    // Low from reset until the first clock edge after release; holds the
    // outputs at 0 and the FSM in FETCH during that window.
    logic       run_q;

    function automatic logic [3:0] rtype_alu_ctl(input logic [5:0] fn);
        logic [3:0] ctl;
        case (fn)
            FN_ADD:  ctl = ALU_ADD;
            FN_SLL:  ctl = ALU_SLL;
            FN_AND:  ctl = ALU_AND;
            FN_NOR:  ctl = ALU_NOR;
            FN_SLT:  ctl = ALU_SLT;
            default: ctl = 4'b0000;
        endcase
        return ctl;
    endfunction

    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE: begin
                case (fn)
                    FN_JR:                                  nxt = S_JR;
                    FN_ADD, FN_SLL, FN_AND, FN_NOR, FN_SLT: nxt = S_REXEC;
                    default:                                nxt = S_TRAP;
                endcase
            end
            OP_ADDI, OP_ANDI: nxt = S_IEXEC;
            OP_BEQ:           nxt = S_BRANCH;
            OP_JAL:           nxt = S_JAL;
            default:          nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

    // State, captured instruction fields and run enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            opcode_q <= 6'd0;
            funct_q  <= 6'd0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
            run_q    <= 1'b1;
        end
    end

    // Next-state, instruction capture and Moore/Mealy output decode
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        funct_d    = funct_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_ctl    = 4'b0000;
        illegal    = 1'b0;
        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctl   = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) state_d = S_DECODE;
                    else           state_d = S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_ctl   = ALU_ADD;
                    // Later states only ever see these captured copies.
                    opcode_d  = opcode;
                    funct_d   = funct;
                    state_d   = decode_next(opcode, funct);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode_q == OP_LW) begin
                        alu_ctl = ALU_LW;
                        state_d = S_MEMRD;
                    end else begin
                        alu_ctl = ALU_SW;
                        state_d = S_MEMWR;
                    end
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    if (mem_ready) state_d = S_MEMWB;
                    else           state_d = S_MEMRD;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                    else           state_d = S_MEMWR;
                end
                S_REXEC: begin
                    alu_src_a = 1'b1;
                    alu_ctl   = rtype_alu_ctl(funct_q);
                    state_d   = S_RWB;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b01;
                    state_d   = S_FETCH;
                end
                S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode_q == OP_ADDI) alu_ctl = ALU_ADDI;
                    else                     alu_ctl = ALU_ANDI;
                    state_d   = S_IWB;
                end
                S_IWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctl   = ALU_BEQ;
                    pc_src    = 2'b01;
                    pc_write  = zero;
                    state_d   = S_FETCH;
                end
                S_JAL: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                    alu_ctl    = ALU_JAL;
                    state_d    = S_FETCH;
                end
                S_JR: begin
                    alu_src_a = 1'b1;
                    alu_ctl   = ALU_JR;
                    pc_src    = 2'b11;
                    pc_write  = 1'b1;
                    state_d   = S_FETCH;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                    state_d = S_TRAP;
                end
                // Unused encodings park in TRAP so a corrupted state is visible.
                default: begin
                    state_d = S_TRAP;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Randomized scoreboard bench. The stimulus side turns each instruction
//   into the phase list its class must walk through, drives one cycle per
//   phase (repeating wait phases while mem_ready is low) and queues the
//   outputs that cycle must show. A separate monitor pops one entry per
//   cycle on the falling edge and compares all outputs plus the state code.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [3:0] alu_ctl;
        logic       illegal;
        logic [3:0] state;
    } exp_t;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_JR = 6, C_ILL = 7;

    logic       clk, rst_n, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src, reg_dst, mem_to_reg;
    logic [3:0] alu_ctl, state;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_ctl(alu_ctl),
        .illegal(illegal), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction class from the encoding rules.
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b001000, 6'b001100: return C_I;
            6'b000100: return C_BEQ;
            6'b000011: return C_JAL;
            6'b000000: begin
                if (fn == 6'b001000) return C_JR;
                if (fn == 6'b100000 || fn == 6'b000000 || fn == 6'b100100 ||
                    fn == 6'b100111 || fn == 6'b101010) return C_R;
                return C_ILL;
            end
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] rfn_code(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b000000: return 4'b0100;
            6'b100100: return 4'b0000;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            default:   return 4'b0000;
        endcase
    endfunction

    // Expected outputs during one cycle of phase ph (-1 = reset / idle, all 0).
    function automatic exp_t expect_out(input int ph, input logic [5:0] op, input logic [5:0] fn,
                                        input logic z, input logic mr);
        exp_t e;
        e = '0;
        if (ph >= 0) e.state = 4'(ph);
        case (ph)
            0:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_ctl = 4'b0010;
                      e.ir_write = mr; e.pc_write = mr; end
            1:  begin e.alu_src_b = 2'b11; e.alu_ctl = 4'b0010; end
            2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                      e.alu_ctl = (op == 6'b100011) ? 4'b1000 : 4'b1001; end
            3:  e.mem_read = 1'b1;
            4:  begin e.reg_write = 1'b1; e.mem_to_reg = 2'b01; end
            5:  e.mem_write = 1'b1;
            6:  begin e.alu_src_a = 1'b1; e.alu_ctl = rfn_code(fn); end
            7:  begin e.reg_write = 1'b1; e.reg_dst = 2'b01; end
            8:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                      e.alu_ctl = (op == 6'b001000) ? 4'b0011 : 4'b0001; end
            9:  e.reg_write = 1'b1;
            10: begin e.alu_src_a = 1'b1; e.alu_ctl = 4'b1010; e.pc_src = 2'b01; e.pc_write = z; end
            11: begin e.pc_write = 1'b1; e.pc_src = 2'b10; e.reg_write = 1'b1; e.reg_dst = 2'b10;
                      e.mem_to_reg = 2'b10; e.alu_ctl = 4'b1011; end
            12: begin e.alu_src_a = 1'b1; e.alu_ctl = 4'b1111; e.pc_src = 2'b11; e.pc_write = 1'b1; end
            13: e.illegal = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic push(input exp_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Immediate check of a condition, reported by name.
    task automatic chk(input bit ok, input string nm);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: state=%0d mem_read=%b mem_write=%b reg_write=%b pc_write=%b illegal=%b",
                     nm, state, mem_read, mem_write, reg_write, pc_write, illegal);
        end
    endtask

    function automatic bit all_zero();
        return ({pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_a,
                 alu_src_b, pc_src, reg_dst, mem_to_reg, alu_ctl, illegal, state} === '0);
    endfunction

    // One phase of an instruction. waits<0: random mem_ready, else mem_ready
    // stays 0 for 'waits' cycles. zv<0: random zero flag.
    task automatic step(input int ph, input logic [5:0] op, input logic [5:0] fn,
                        input int waits, input int zv, input string tag);
        int n;
        bit mr, done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            if (waits < 0) mr = (n >= 16) || ($urandom_range(3, 0) != 0);
            else           mr = (n >= waits);
            mem_ready = mr;
            zero = (zv < 0) ? 1'($urandom_range(1, 0)) : zv[0];
            if (ph == 1) begin
                opcode = op;
                funct  = fn;
            end else begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end
            push(expect_out(ph, op, fn, zero, mr), $sformatf("%s.s%0d.c%0d", tag, ph, n));
            @(posedge clk); #1;
            n++;
            done = !((ph == 0 || ph == 3 || ph == 5) && !mr);
            if ((ph == 3 || ph == 5) && waits > 0 && mr)
                chk(state === ((ph == 3) ? 4'd4 : 4'd0),
                    $sformatf("%s.s%0d.wait_expired", tag, ph));
        end
    endtask

    // Hold reset for k cycles, then release; outputs stay 0 until the first
    // edge after release.
    task automatic reset_seq(input int k);
        for (int i = 0; i < k; i++) begin
            rst_n = 1'b0;
            mem_ready = 1'($urandom_range(1, 0));
            opcode = 6'($urandom);
            funct = 6'($urandom);
            #1;
            chk(all_zero(), $sformatf("reset_state.c%0d", i));
            push(expect_out(-1, 6'd0, 6'd0, 1'b0, 1'b0), "reset");
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        mem_ready = 1'($urandom_range(1, 0));
        push(expect_out(-1, 6'd0, 6'd0, 1'b0, 1'b0), "release");
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zv,
                             input int fw, input int mw);
        int c;
        string t;
        c = classify(op, fn);
        t = $sformatf("op%02h_fn%02h", op, fn);
        step(0, op, fn, fw, zv, t);
        step(1, op, fn, -1, zv, t);
        case (c)
            C_LW:  begin step(2, op, fn, -1, zv, t); step(3, op, fn, mw, zv, t); step(4, op, fn, -1, zv, t); end
            C_SW:  begin step(2, op, fn, -1, zv, t); step(5, op, fn, mw, zv, t); end
            C_R:   begin step(6, op, fn, -1, zv, t); step(7, op, fn, -1, zv, t); end
            C_I:   begin step(8, op, fn, -1, zv, t); step(9, op, fn, -1, zv, t); end
            C_BEQ: step(10, op, fn, -1, zv, t);
            C_JAL: step(11, op, fn, -1, zv, t);
            C_JR:  step(12, op, fn, -1, zv, t);
            default: begin
                for (int i = 0; i < 10; i++) step(13, op, fn, -1, zv, t);
                reset_seq(2);
            end
        endcase
    endtask

    // Reset lands in the middle of a memory wait cycle, away from any clock edge.
    task automatic abort_mem(input logic [5:0] op);
        int ph;
        string t;
        ph = (op == 6'b100011) ? 3 : 5;
        t = $sformatf("abort_op%02h", op);
        step(0, op, 6'd0, 0, -1, t);
        step(1, op, 6'd0, -1, -1, t);
        step(2, op, 6'd0, -1, -1, t);
        mem_ready = 1'b0;
        push(expect_out(ph, op, 6'd0, 1'b0, 1'b0), $sformatf("%s.wait", t));
        @(posedge clk); #1;
        mem_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk(all_zero(), $sformatf("%s.async_immediate", t));
        push(expect_out(-1, 6'd0, 6'd0, 1'b0, 1'b0), $sformatf("%s.async", t));
        @(posedge clk); #1;
        reset_seq(1);
    endtask

    // Monitor: one expected entry per cycle, compared on the falling edge.
    initial begin
        exp_t  e, a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_a,
                      alu_src_b, pc_src, reg_dst, mem_to_reg, alu_ctl, illegal, state};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got=%06h (state %0d) expected=%06h (state %0d)",
                             nm, a, a.state, e, e.state);
                end
            end
        end
    end

    logic [5:0] legal_op [12];
    logic [5:0] legal_fn [12];

    initial begin
        int k;
        legal_op = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                     6'b000000, 6'b000000, 6'b001000, 6'b001100, 6'b000100, 6'b000011};
        legal_fn = '{6'b000101, 6'b110011, 6'b100000, 6'b000000, 6'b100100, 6'b100111,
                     6'b101010, 6'b001000, 6'b010101, 6'b111000, 6'b000111, 6'b101010};
        rst_n = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        opcode = 6'd0;
        funct = 6'd0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        reset_seq(3);

        run_instr(6'b100011, 6'd0, -1, 0, 0);          // lw, mem_ready high
        run_instr(6'b000000, 6'b100111, -1, 0, 0);     // nor
        run_instr(6'b000100, 6'd0, 0, 0, 0);           // beq not taken
        run_instr(6'b000100, 6'd0, 1, 0, 0);           // beq taken
        run_instr(6'b101011, 6'd0, -1, 0, 3);          // sw, 3 wait cycles
        run_instr(6'b100011, 6'd0, -1, 2, 2);          // lw with fetch and read waits
        for (int i = 0; i < 12; i++) run_instr(legal_op[i], legal_fn[i], -1, 0, 0);
        run_instr(6'b111111, 6'd0, -1, 0, 0);          // illegal opcode -> TRAP
        run_instr(6'b000000, 6'b000001, -1, 0, 0);     // bad R-type funct
        abort_mem(6'b100011);
        abort_mem(6'b101011);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                run_instr(6'($urandom), 6'($urandom), -1, -1, -1);
            end else begin
                k = $urandom_range(11, 0);
                if (legal_op[k] == 6'b000000) run_instr(legal_op[k], legal_fn[k], -1, -1, -1);
                else                          run_instr(legal_op[k], 6'($urandom), -1, -1, -1);
            end
        end

        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
